passcode_ctrl: RTL and testbench
================================

// Module: passcode_ctrl
// PURPOSE
// - Supervises the digital-lock FSM: owns the 32-bit passcode register (seq), runs passcode programming from the keypad, and enforces alarm lockout.
// - Sits between keypad decoder (key/key_strb) and lock FSM; drives the FSM's seq input and active-high reset; observes its state_t.
// PARAMETERS
// - DEFAULT_SEQ     32'h1234_5678  passcode loaded at reset
// - LOCKOUT_CYCLES  1000           base alarm lockout duration, clk cycles (>=2)
// - MAX_FAILS       3              alarm count that latches permanent lockout (1..15)
// PORTS
// - clk        in   1   clock, single domain, posedge
// - nrst       in   1   asynchronous active-low reset
// - key        in   5   keypad code: 0-15 hex digit, 16=W, 17=P (program), 18=C (clear)
// - key_strb   in   1   one-cycle pulse, key valid
// - lock_state in   state_t  current lock FSM state
// - seq        out  32  passcode to FSM, digit 0 in [31:28]
// - prog_mode  out  1   high in PROG/COMMIT
// - lockout    out  1   high in LOCKOUT/PERMA
// - fsm_clr    out  1   one-cycle active-high reset pulse to lock FSM
// - fail_cnt   out  4   alarms since reset, saturating at 15
// BEHAVIOUR
// - Reset: state RUN, seq=DEFAULT_SEQ, prog_mode=0, lockout=0, fsm_clr=0, fail_cnt=0, digit_idx=0.
// - Only cycles with key_strb=1 consume keys; other key values ignored.
// - RUN: P while lock_state==OPEN -> PROG, digit_idx=0, shadow=0. P otherwise ignored.
//   lock_state==ALARM -> LOCKOUT, fail_cnt+=1 (sat), timer loaded; if new fail_cnt>=MAX_FAILS -> PERMA instead.
// - PROG: hex digit -> shadow[31-4*idx -: 4]=key, idx+=1; 8th digit -> COMMIT. W before 8 digits ignored.
//   C -> RUN, shadow discarded, seq unchanged. lock_state leaving OPEN (W re-entry) -> RUN, abort.
// - COMMIT: W -> seq<=shadow (visible next cycle), fsm_clr pulse, -> RUN. C -> RUN, discarded. Digits ignored.
// - LOCKOUT: timer counts down to 0, then fsm_clr pulses one cycle, -> RUN. All keys ignored.
//   Duration from ALARM sample to fsm_clr = LOCKOUT_CYCLES cycles exactly.
// - PERMA: lockout=1 forever, fsm_clr never asserted; exit only via nrst.
// - fsm_clr registered; lockout and prog_mode are registered state decodes.
// - Priority same cycle: ALARM observation > key handling.
// - nrst mid-programming: shadow lost, seq back to DEFAULT_SEQ.
// CONFIGURATION
// - PASSCODE_CTRL_BACKOFF_EN defined: lockout duration = LOCKOUT_CYCLES << (fail_cnt-1), fail_cnt after increment;
//   timer width sized for LOCKOUT_CYCLES<<(MAX_FAILS-1).
// - Undefined: every lockout is LOCKOUT_CYCLES.
// STRUCTURE
// - lock_pkg: state_t (INIT, LS0..LS7, OPEN, ALARM), KEY_W=5'd16, KEY_P=5'd17, KEY_C=5'd18, ctrl state enum.
// - Sub-module lockout_timer: load/count-down/done pulse, parameterised width.
// - Top: controller FSM (RUN, PROG, COMMIT, LOCKOUT, PERMA), shadow register, digit index, fail counter.
// TESTING
// - Reset -> seq=32'h12345678, fail_cnt=0, lockout=0, fsm_clr=0.
// - lock_state=OPEN, P, digits 8,7,6,5,4,3,2,1, W -> seq=32'h87654321 next cycle, one fsm_clr pulse.
// - PROG, 5 digits then C -> seq unchanged, prog_mode=0; P with lock_state=LS3 -> ignored.
// - lock_state=ALARM -> lockout=1, fail_cnt=1, fsm_clr exactly 1000 cycles later, lockout=0.
// - Three ALARM events -> third enters PERMA, no fsm_clr for 5000 cycles; nrst low clears.
// - BACKOFF_EN: second lockout 2000 cycles; nrst during PROG at digit 4 -> RUN, DEFAULT_SEQ.

Source files
------------

// File: rtl/lock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lock_pkg - shared types and key codes for the lock supervisor        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lock_pkg;

  typedef enum logic [3:0] {
    INIT, LS0, LS1, LS2, LS3, LS4, LS5, LS6, LS7, OPEN, ALARM
  } state_t;

  localparam logic [4:0] KEY_W = 5'd16;
  localparam logic [4:0] KEY_P = 5'd17;
  localparam logic [4:0] KEY_C = 5'd18;

  typedef enum logic [2:0] {
    CTRL_RUN, CTRL_PROG, CTRL_COMMIT, CTRL_LOCKOUT, CTRL_PERMA
  } ctrl_state_t;

  function automatic logic is_digit(input logic [4:0] k);
    return k < 5'd16;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lockout_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockout_timer - loadable down-counter with one-cycle done pulse      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lockout_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;
  logic             busy;

  // A load of N-1 raises done N-1 cycles later, so the registered consumer
  // acts exactly N cycles after the load edge.
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/passcode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | passcode_ctrl - passcode owner, keypad programming, alarm lockout    |
// | Option: PASSCODE_CTRL_BACKOFF_EN doubles lockout per prior alarm     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
import lock_pkg::*;

module passcode_ctrl #(
  parameter logic [31:0] DEFAULT_SEQ    = 32'h1234_5678,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          MAX_FAILS      = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  key,
  input  logic        key_strb,
  input  state_t      lock_state,
  output logic [31:0] seq,
  output logic        prog_mode,
  output logic        lockout,
  output logic        fsm_clr,
  output logic [3:0]  fail_cnt
);

`ifdef PASSCODE_CTRL_BACKOFF_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1) + MAX_FAILS - 1;
`else
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
`endif

  ctrl_state_t    state, state_nxt;
  logic [31:0]    shadow, shadow_nxt, seq_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [3:0]     fail_nxt, fail_inc;
  logic [4:0]     digit_sh;
  logic           clr_nxt, alarm_hit;
  logic           tmr_load, tmr_done;
  logic [TW-1:0]  tmr_val;

  assign fail_inc  = (fail_cnt == 4'd15) ? 4'd15 : fail_cnt + 4'd1;
  assign digit_sh  = 5'd28 - {idx, 2'b00};
  assign alarm_hit = (lock_state == ALARM) &&
                     (state == CTRL_RUN || state == CTRL_PROG || state == CTRL_COMMIT);

`ifdef PASSCODE_CTRL_BACKOFF_EN
  assign tmr_val = (TW'(LOCKOUT_CYCLES) << (fail_inc - 4'd1)) - TW'(1);
`else
  assign tmr_val = TW'(LOCKOUT_CYCLES - 1);
`endif

  lockout_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= CTRL_RUN;
      shadow    <= '0;
      idx       <= '0;
      seq       <= DEFAULT_SEQ;
      fail_cnt  <= '0;
      fsm_clr   <= 1'b0;
      prog_mode <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      idx       <= idx_nxt;
      seq       <= seq_nxt;
      fail_cnt  <= fail_nxt;
      fsm_clr   <= clr_nxt;
      prog_mode <= (state_nxt == CTRL_PROG) || (state_nxt == CTRL_COMMIT);
      lockout   <= (state_nxt == CTRL_LOCKOUT) || (state_nxt == CTRL_PERMA);
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    idx_nxt    = idx;
    seq_nxt    = seq;
    fail_nxt   = fail_cnt;
    clr_nxt    = 1'b0;
    tmr_load   = 1'b0;

    // An alarm seen by the lock FSM overrides whatever key arrives with it.
    if (alarm_hit) begin
      fail_nxt = fail_inc;
      if (int'(fail_inc) >= MAX_FAILS) begin
        state_nxt = CTRL_PERMA;
      end else begin
        state_nxt = CTRL_LOCKOUT;
        tmr_load  = 1'b1;
      end
    end else begin
      case (state)
        CTRL_RUN: begin
          if (key_strb && key == KEY_P && lock_state == OPEN) begin
            state_nxt  = CTRL_PROG;
            idx_nxt    = '0;
            shadow_nxt = '0;
          end
        end
        CTRL_PROG: begin
          if (lock_state != OPEN) begin
            state_nxt = CTRL_RUN;
          end else if (key_strb) begin
            if (is_digit(key)) begin
              shadow_nxt = (shadow & ~(32'hF << digit_sh)) | ({28'd0, key[3:0]} << digit_sh);
              idx_nxt    = idx + 3'd1;
              if (idx == 3'd7) state_nxt = CTRL_COMMIT;
            end else if (key == KEY_C) begin
              state_nxt = CTRL_RUN;
            end
          end
        end
        CTRL_COMMIT: begin
          if (key_strb && key == KEY_W) begin
            seq_nxt   = shadow;
            clr_nxt   = 1'b1;
            state_nxt = CTRL_RUN;
          end else if (key_strb && key == KEY_C) begin
            state_nxt = CTRL_RUN;
          end
        end
        CTRL_LOCKOUT: begin
          if (tmr_done) begin
            clr_nxt   = 1'b1;
            state_nxt = CTRL_RUN;
          end
        end
        CTRL_PERMA: state_nxt = CTRL_PERMA;
        default:    state_nxt = CTRL_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_passcode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_passcode_ctrl - scoreboard bench for passcode_ctrl                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
import lock_pkg::*;

module tb_passcode_ctrl;

  localparam int LC = 1000;
  localparam int MF = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [4:0]  key = 5'd0;
  logic        key_strb = 1'b0;
  state_t      lock_state = INIT;
  logic [31:0] seq;
  logic        prog_mode, lockout, fsm_clr;
  logic [3:0]  fail_cnt;

  passcode_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .key        (key),
    .key_strb   (key_strb),
    .lock_state (lock_state),
    .seq        (seq),
    .prog_mode  (prog_mode),
    .lockout    (lockout),
    .fsm_clr    (fsm_clr),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] seq;
    logic [3:0]  fails;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          clr_seen = 0;
  logic [31:0] exp_seq = 32'h1234_5678;
  logic [3:0]  exp_fails = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic int dur(input int f);
`ifdef PASSCODE_CTRL_BACKOFF_EN
    return LC << (f - 1);
`else
    return (f > 0) ? LC : LC;
`endif
  endfunction

  // Monitor: every fsm_clr pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (nrst && fsm_clr) begin
      clr_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_clr: got fsm_clr=1 at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("clr_cycle", cyc, e.cyc);
        chk("clr_seq", seq, e.seq);
        chk("clr_fails", {28'd0, fail_cnt}, {28'd0, e.fails});
      end
    end
  end

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    key = k;
    key_strb = 1'b1;
    @(posedge clk);
    #1;
    key_strb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter_code(input logic [31:0] code);
    logic [3:0] d;
    for (int i = 0; i < 8; i++) begin
      d = code[31-4*i -: 4];
      press({1'b0, d});
    end
  endtask

  task automatic commit_w(input logic [31:0] code);
    exp_seq = code;
    q.push_back('{cyc + 1, code, exp_fails});
    press(KEY_W);
  endtask

  task automatic raise_alarm(output int target);
    int e;
    @(negedge clk);
    lock_state = ALARM;
    @(posedge clk);
    #1;
    lock_state = INIT;
    e = cyc;
    exp_fails = (exp_fails == 4'd15) ? 4'd15 : exp_fails + 4'd1;
    target = e + dur(int'(exp_fails));
    if (int'(exp_fails) < MF) q.push_back('{target, exp_seq, exp_fails});
  endtask

  task automatic lockout_round(input logic [3:0] n);
    int tgt;
    raise_alarm(tgt);
    chk("alarm_lockout", {31'd0, lockout}, 32'd1);
    chk("alarm_fails", {28'd0, fail_cnt}, {28'd0, n});
    lock_state = OPEN;
    press(KEY_P);
    chk("lockout_ignores_p", {31'd0, prog_mode}, 32'd0);
    lock_state = INIT;
    while (cyc < tgt + 2) idle(1);
    chk("lockout_released", {31'd0, lockout}, 32'd0);
    chk("lockout_clr_seen", q.size(), 32'd0);
  endtask

  initial begin
    int tgt;
    int n0;
    idle(3);
    chk("rst_seq", seq, 32'h1234_5678);
    chk("rst_fails", {28'd0, fail_cnt}, 32'd0);
    chk("rst_lockout", {31'd0, lockout}, 32'd0);
    chk("rst_clr", {31'd0, fsm_clr}, 32'd0);
    chk("rst_prog", {31'd0, prog_mode}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Program 87654321.
    lock_state = OPEN;
    press(KEY_P);
    chk("prog_enter", {31'd0, prog_mode}, 32'd1);
    enter_code(32'h8765_4321);
    chk("commit_prog", {31'd0, prog_mode}, 32'd1);
    chk("commit_seq_hold", seq, 32'h1234_5678);
    commit_w(32'h8765_4321);
    chk("commit_seq", seq, 32'h8765_4321);
    chk("commit_exit", {31'd0, prog_mode}, 32'd0);
    lock_state = INIT;
    idle(2);

    // Early W ignored, C discards.
    lock_state = OPEN;
    press(KEY_P);
    for (int i = 1; i <= 5; i++) press(5'(i));
    press(KEY_W);
    chk("early_w_ignored", {31'd0, prog_mode}, 32'd1);
    press(KEY_C);
    chk("clear_exit", {31'd0, prog_mode}, 32'd0);
    chk("clear_seq", seq, 32'h8765_4321);

    lock_state = LS3;
    press(KEY_P);
    chk("p_not_open", {31'd0, prog_mode}, 32'd0);

    // Lock leaves OPEN mid-entry.
    lock_state = OPEN;
    press(KEY_P);
    press(5'd4);
    press(5'd2);
    lock_state = LS0;
    idle(1);
    chk("abort_exit", {31'd0, prog_mode}, 32'd0);

    // Digits in COMMIT are ignored.
    lock_state = OPEN;
    press(KEY_P);
    enter_code(32'hDEAD_BEEF);
    press(5'd0);
    commit_w(32'hDEAD_BEEF);
    chk("commit2_seq", seq, 32'hDEAD_BEEF);
    lock_state = INIT;

    // C in COMMIT discards.
    lock_state = OPEN;
    press(KEY_P);
    enter_code(32'h1111_1111);
    press(KEY_C);
    chk("commit_c_exit", {31'd0, prog_mode}, 32'd0);
    chk("commit_c_seq", seq, 32'hDEAD_BEEF);
    lock_state = INIT;

    lockout_round(4'd1);
    lockout_round(4'd2);

    raise_alarm(tgt);
    chk("perma_lockout", {31'd0, lockout}, 32'd1);
    chk("perma_fails", {28'd0, fail_cnt}, 32'd3);
    n0 = clr_seen;
    idle(5000);
    chk("perma_no_clr", clr_seen - n0, 32'd0);
    chk("perma_held", {31'd0, lockout}, 32'd1);
    lock_state = OPEN;
    press(KEY_P);
    chk("perma_ignores_p", {31'd0, prog_mode}, 32'd0);
    lock_state = INIT;

    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("perma_rst_lockout", {31'd0, lockout}, 32'd0);
    chk("perma_rst_fails", {28'd0, fail_cnt}, 32'd0);
    exp_fails = 4'd0;
    exp_seq = 32'h1234_5678;
    idle(2);
    @(negedge clk);
    nrst = 1'b1;

    // Reset while programming.
    lock_state = OPEN;
    press(KEY_P);
    enter_code(32'h0123_4567);
    commit_w(32'h0123_4567);
    chk("commit3_seq", seq, 32'h0123_4567);
    press(KEY_P);
    for (int i = 9; i <= 12; i++) press(5'(i));
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("prog_rst_seq", seq, 32'h1234_5678);
    chk("prog_rst_mode", {31'd0, prog_mode}, 32'd0);
    exp_seq = 32'h1234_5678;
    idle(2);
    @(negedge clk);
    nrst = 1'b1;
    press(KEY_W);
    press(5'd5);
    chk("post_rst_idle", {31'd0, prog_mode}, 32'd0);
    chk("post_rst_seq", seq, 32'h1234_5678);
    lock_state = INIT;
    idle(3);
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
